// File: rtl/trigger_sequencer.sv
// trigger_sequencer
// Qualifies edges on the registered comparator outputs (q, z) and sequences a
// single-shot acquisition: pre-trigger fill, armed wait, post-trigger capture
// and holdoff. The block drives the sample-buffer write enable and a one-cycle
// trigger marker. Software re-arms it through the register interface.
//
// Optional feature macro: AUTO_TRIGGER_EN
//   When it is defined, the block adds input auto_timeout and output trig_auto,
//   and the ARMED state forces a trigger after auto_timeout cycles.
//   When it is undefined, the block triggers on qualified edges only.

module trigger_sequencer #(
   parameter int CNT_W  = 16,
   parameter int HOLD_W = 16
`ifdef AUTO_TRIGGER_EN
  ,parameter int AUTO_W = 24
`endif
) (
   input  logic              clkIn,
   input  logic              nrstIn,
   input  logic              arm,
   input  logic              abort,
   input  logic              q,
   input  logic              z,
   input  logic [1:0]        edge_sel,
   input  logic [CNT_W-1:0]  pre_count,
   input  logic [CNT_W-1:0]  post_count,
   input  logic [HOLD_W-1:0] holdoff,
`ifdef AUTO_TRIGGER_EN
   input  logic [AUTO_W-1:0] auto_timeout,
   output logic              trig_auto,
`endif
   output logic              trig_pulse,
   output logic              capture_en,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRE     = 3'd1,
      ST_ARMED   = 3'd2,
      ST_POST    = 3'd3,
      ST_HOLDOFF = 3'd4
   } seqState_t;

   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

   seqState_t         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [HOLD_W-1:0] r_holdCnt;
   logic              r_qD;
   logic [1:0]        r_edgeSel;
   logic [CNT_W-1:0]  r_pre;
   logic [CNT_W-1:0]  r_post;
   logic [HOLD_W-1:0] r_hold;
   logic              r_trigPulse;
   logic              r_captureEn;
   logic              r_busy;
   logic              r_done;

   logic              w_rise;
   logic              w_fall;
   logic              w_qualEdge;
   logic              w_fire;
   logic              w_preLast;
   logic              w_postLast;
   logic              w_holdLast;
   logic [CNT_W-1:0]  w_postLim;
   logic [HOLD_W-1:0] w_holdLim;
   logic [CNT_W-1:0]  w_cntInc;
   logic [HOLD_W-1:0] w_holdInc;

`ifdef AUTO_TRIGGER_EN
   localparam logic [AUTO_W-1:0] AUTO_ONE = {{(AUTO_W-1){1'b0}}, 1'b1};

   logic [AUTO_W-1:0] r_autoCnt;
   logic              r_trigAuto;
   logic              w_autoFire;
   logic [AUTO_W-1:0] w_autoInc;

   assign w_autoInc  = (r_autoCnt == {AUTO_W{1'b1}}) ? r_autoCnt : (r_autoCnt + AUTO_ONE);
   assign w_autoFire = (auto_timeout != '0) && (r_autoCnt == (auto_timeout - AUTO_ONE));
   assign w_fire     = w_qualEdge | w_autoFire;
   assign trig_auto  = r_trigAuto;
`else
   assign w_fire     = w_qualEdge;
`endif

   // Raw edges; while z is high, q is frozen upstream, so the block ignores edges there.
   assign w_rise = ~z &  q & ~r_qD;
   assign w_fall = ~z & ~q &  r_qD;

   // A zero post or holdoff length still gives one cycle in that state.
   assign w_postLim = (r_post == '0) ? '0 : (r_post - CNT_ONE);
   assign w_holdLim = (r_hold == '0) ? '0 : (r_hold - HOLD_ONE);

   assign w_preLast  = (r_cnt == (r_pre - CNT_ONE));
   assign w_postLast = (r_cnt == w_postLim);
   assign w_holdLast = (r_holdCnt == w_holdLim);

   // The counters saturate at all-ones instead of wrapping.
   assign w_cntInc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_ONE);
   assign w_holdInc = (r_holdCnt == {HOLD_W{1'b1}}) ? r_holdCnt : (r_holdCnt + HOLD_ONE);

   assign trig_pulse = r_trigPulse;
   assign capture_en = r_captureEn;
   assign busy       = r_busy;
   assign done       = r_done;
   assign state      = r_state;

   // Select which raw edge counts as a trigger, using the edge select latched at arm time.
   always_comb begin
      w_qualEdge = 1'b0;
      case (r_edgeSel)
         2'b00:   w_qualEdge = w_rise;
         2'b01:   w_qualEdge = w_fall;
         2'b10:   w_qualEdge = w_rise | w_fall;
         default: w_qualEdge = 1'b0;
      endcase
   end

   // One-cycle history of q for edge detection, updated in every state.
   always_ff @(posedge clkIn or negedge nrstIn) begin
      if (!nrstIn) begin
         r_qD <= 1'b0;
      end else begin
         r_qD <= q;
      end
   end

   // Acquisition sequencer; the outputs are registered along with the next state.
   always_ff @(posedge clkIn or negedge nrstIn) begin
      if (!nrstIn) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_holdCnt   <= '0;
         r_edgeSel   <= 2'b00;
         r_pre       <= '0;
         r_post      <= '0;
         r_hold      <= '0;
         r_trigPulse <= 1'b0;
         r_captureEn <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef AUTO_TRIGGER_EN
         r_autoCnt   <= '0;
         r_trigAuto  <= 1'b0;
`endif
      end else begin
         r_trigPulse <= 1'b0;
`ifdef AUTO_TRIGGER_EN
         r_trigAuto  <= 1'b0;
`endif
         if (abort) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_holdCnt   <= '0;
            r_captureEn <= 1'b0;
            r_busy      <= 1'b0;
`ifdef AUTO_TRIGGER_EN
            r_autoCnt   <= '0;
`endif
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (arm) begin
                     r_edgeSel   <= edge_sel;
                     r_pre       <= pre_count;
                     r_post      <= post_count;
                     r_hold      <= holdoff;
                     r_cnt       <= '0;
                     r_holdCnt   <= '0;
                     r_done      <= 1'b0;
                     r_busy      <= 1'b1;
                     r_captureEn <= 1'b1;
`ifdef AUTO_TRIGGER_EN
                     r_autoCnt   <= '0;
`endif
                     r_state     <= (pre_count == '0) ? ST_ARMED : ST_PRE;
                  end
               end
               ST_PRE: begin
                  if (w_preLast) begin
                     r_cnt   <= '0;
                     r_state <= ST_ARMED;
                  end else begin
                     r_cnt   <= w_cntInc;
                  end
               end
               ST_ARMED: begin
                  if (w_fire) begin
                     r_cnt       <= '0;
                     r_trigPulse <= 1'b1;
                     r_state     <= ST_POST;
`ifdef AUTO_TRIGGER_EN
                     r_trigAuto  <= ~w_qualEdge;
                     r_autoCnt   <= '0;
`endif
                  end else begin
`ifdef AUTO_TRIGGER_EN
                     r_autoCnt   <= w_autoInc;
`endif
                  end
               end
               ST_POST: begin
                  if (w_postLast) begin
                     r_holdCnt   <= '0;
                     r_captureEn <= 1'b0;
                     r_state     <= ST_HOLDOFF;
                  end else begin
                     r_cnt       <= w_cntInc;
                  end
               end
               ST_HOLDOFF: begin
                  if (w_holdLast) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_holdCnt <= w_holdInc;
                  end
               end
               default: begin
                  r_cnt       <= '0;
                  r_holdCnt   <= '0;
                  r_captureEn <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
